shiftreg_universal: RTL

- Parametrised universal shift register. It generalises the 8-bit hold/load/shift-right register to WIDTH bits.
- Adds left shift, rotates, arithmetic shift, synchronous clear, an enable, and serial outputs at both ends.
- A burst engine performs N consecutive shift/rotate ops from one start pulse, with busy/done handshake.
- Sits in the datapath as a parallel-load/serial-shift element, for example feeding a serial TX or a bit-serial multiplier.

---
 rtl/shiftreg_pkg.sv | 52 +++++
 rtl/shiftreg_burst_ctrl.sv | 68 ++++++
 rtl/shiftreg_universal.sv | 70 +++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared op codes, burst FSM state type and the next-value function used by
// both the single-op and burst datapaths of shiftreg_universal.
package shiftreg_pkg;

  // next_val works on a fixed-width container; register widths up to this size are supported
  localparam int unsigned SR_MAX_W = 64;
  localparam int unsigned SR_IDX_W = $clog2(SR_MAX_W);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_burst_op(input logic [2:0] op);
    return (op >= OP_SHR) && (op <= OP_ASR);
  endfunction

  // cur must be zero-extended from w bits; bits above w-1 of the result are don't-care
  function automatic logic [SR_MAX_W-1:0] next_val(
    input logic [2:0]          op,
    input logic [SR_MAX_W-1:0] cur,
    input int unsigned         w,
    input logic                sin_r,
    input logic                sin_l
  );
    logic [SR_MAX_W-1:0] r;
    logic [SR_IDX_W-1:0] msb;
    msb = SR_IDX_W'(w - 1);
    r   = cur;
    case (op)
      OP_SHR: begin r = cur >> 1; r[msb] = sin_r;    end
      OP_SHL: begin r = cur << 1; r[0]   = sin_l;    end
      OP_ROR: begin r = cur >> 1; r[msb] = cur[0];   end
      OP_ROL: begin r = cur << 1; r[0]   = cur[msb]; end
      OP_ASR: begin r = cur >> 1; r[msb] = cur[msb]; end
      OP_CLR: r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shiftreg_burst_ctrl.sv
// Burst sequencer: IDLE/BURST/DONE FSM with a saturating-load down-counter
// that latches the burst op and says when the datapath should apply it.
module shiftreg_burst_ctrl
  import shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       ctrl,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             burst_active,
  output logic [2:0]       op_q
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_sat;
  logic             accept;

  assign accept  = burst_start && is_burst_op(ctrl) && (state != S_BURST);
  assign len_sat = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_nxt = (burst_len == '0) ? S_DONE : S_BURST;
        else
          state_nxt = S_IDLE;
      end
      S_BURST: begin
        if (en && (cnt == CNT_W'(1))) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (state == S_BURST);
    done         = (state == S_DONE);
    burst_active = (state == S_BURST) && en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= OP_HOLD;
    end else if (accept) begin
      cnt  <= len_sat;
      op_q <= ctrl;
    end else if (burst_active) begin
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/shiftreg_universal.sv
// Parametrised universal shift register: single ops on ctrl, or N-op bursts
// sequenced by shiftreg_burst_ctrl. Top holds only the next-value mux and register.
module shiftreg_universal
  import shiftreg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_in_r,
  input  logic             shift_in_l,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0]    data_q, data_nxt;
  logic [SR_MAX_W-1:0] cur_ext;
  logic [2:0]          op_q;
  logic                burst_active;
  logic                single_op;

  shiftreg_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .ctrl         (ctrl),
    .burst_start  (burst_start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .burst_active (burst_active),
    .op_q         (op_q)
  );

  // any accepted burst request (including len 0) suppresses the single op that cycle
  assign single_op = en && !busy && !(burst_start && is_burst_op(ctrl));
  assign cur_ext   = SR_MAX_W'(data_q);

  always_comb begin
    data_nxt = data_q;
    if (burst_active)
      data_nxt = WIDTH'(next_val(op_q, cur_ext, WIDTH, shift_in_r, shift_in_l));
    else if (single_op)
      data_nxt = (ctrl == OP_LOAD) ? data_in
                                   : WIDTH'(next_val(ctrl, cur_ext, WIDTH, shift_in_r, shift_in_l));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= RESET_VAL;
    else        data_q <= data_nxt;
  end

  assign data_out     = data_q;
  assign serial_out_r = data_q[0];
  assign serial_out_l = data_q[WIDTH-1];

endmodule
